bcd_count_ctrl: RTL
===================

# bcd_count_ctrl

Sequencing controller for the three-digit BCD incrementer datapath, three chained `bcd_incrementer` digits. It owns the 12-bit count register and decides on which cycles the datapath's enable is asserted: start/stop/clear/load control, a tick prescaler, and terminal-count handling. It sits between the timebase that produces `tick` pulses and the display/readout logic that consumes `count`.

## Interface
- `DIV`, default 1: number of `tick` pulses per count increment; legal range 1–1023.
- `STOP_AT_MAX`, default 0: 0 wraps 999→000 and keeps running; 1 stops at 999 and enters DONE.
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled; begin or resume counting.
- `stop` in 1: pause counting and hold `count`.
- `clr` in 1: zero `count`, prescaler and `ovf`; go to IDLE.
- `load` in 1: load `load_val` into `count`.
- `load_val` in 12: three BCD digits; [3:0] is ones, [11:8] is hundreds.
- `tick` in 1: single-cycle timebase enable.
- `count` out 12: registered BCD count.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE (only when STOP_AT_MAX=1).
- `wrap` out 1: one-cycle pulse on the 999→000 transition.
- `ovf` out 1: sticky; set with `wrap`, cleared only by `clr` or reset.
- `load_err` out 1: one-cycle pulse when `load` is rejected.

## Operation
- FSM states:
  - IDLE: reset state; not counting.
  - RUN: counting.
  - PAUSE: stopped by `stop`; `count` held.
  - DONE: reached 999 with STOP_AT_MAX=1.
- Command priority per cycle: `clr` > `load` > `stop` > `start` > `tick`. Only the highest-priority asserted command acts; lower ones are ignored that cycle.
- `clr`:
  - `count`←0, prescaler←0, `ovf`←0.
  - State←IDLE from any state.
- `load`:
  - Accepted only if every digit of `load_val` ≤ 9. Then `count`←`load_val` and prescaler←0; state is unchanged, except DONE→IDLE.
  - Otherwise `count` is unchanged and `load_err` pulses.
  - Legal in any state.
- `stop`: RUN→PAUSE; no effect in other states.
- `start`:
  - IDLE or PAUSE → RUN.
  - No effect in RUN.
  - In DONE, `start` is ignored; only `clr` or `load` leaves DONE.
- `tick` in RUN with no higher-priority command:
  - If prescaler = DIV-1: prescaler←0 and the incrementer enable is asserted; otherwise prescaler increments.
  - Ticks are ignored outside RUN; the prescaler holds its value across PAUSE.
- Increment:
  - `count`← the datapath output.
  - If the datapath carry-out is set (count was 999): `count` becomes 000, `wrap` pulses and `ovf` sets.
- With STOP_AT_MAX=1, if the increment would take `count` from 999, no increment occurs. Instead: `count` stays 999, state→DONE, `wrap` does not pulse, and `ovf` is not set.
- Prescaler width is ceil(log2(DIV)), minimum 1 bit. With DIV=1, every tick increments.

## Timing
- Reset values:
  - `count`=000, prescaler=0, state=IDLE.
  - `running`, `done`, `wrap`, `ovf` and `load_err` all 0.
- All outputs are registered. A command sampled at edge N is visible after edge N.
- `running` rises the cycle after `start` is sampled.
- Latency from the qualifying `tick` to the updated `count` is 1 cycle.
- `start` and `tick` in the same cycle in IDLE: the state goes to RUN and the tick is not counted.
- `stop` and `tick` in the same cycle in RUN: the tick is dropped.
- Back-to-back ticks at DIV=1 increment on every cycle.
- `wrap` and `load_err` are exactly one cycle wide.
- `reset_n` asserted mid-count clears everything immediately, without waiting for `clk`.

## Structure
- Shared package `bcd_pkg`:
  - State enum (IDLE, RUN, PAUSE, DONE).
  - Constants BCD_MAX=12'h999 and DIGIT_MAX=4'd9.
  - Function `bcd_valid3` for `load_val` checking.
- One sub-module: the three-digit incrementer datapath, instantiated once. It is built from the existing `bcd_incrementer` digits and has no registers.
- The controller contains the FSM, prescaler, count register and flag logic only.

## Test plan
- Reset, `start`, then 12 ticks with DIV=1 → `count`=012 and `running`=1. After `stop` → PAUSE; 3 more ticks leave `count` at 012.
- `load` 12'h998 with STOP_AT_MAX=0, `start`, 3 ticks → 999, 000 (`wrap` pulse, `ovf`=1), 001; `ovf` stays 1 until `clr`.
- STOP_AT_MAX=1, `load` 12'h998, `start`, 3 ticks → 999, then `done`=1 with `count` held at 999 and `ovf`=0. `start` is ignored; `clr` → IDLE with `count`=000.
- `load` 12'h1A5 → `load_err` pulses for 1 cycle and `count` is unchanged. `load` 12'h105 → `count`=105.
- DIV=4, RUN, 10 ticks → `count`=002, with increments on the 4th and 8th ticks. `stop` after the 9th tick, `start`, 3 more ticks → `count`=003.
- Same-cycle `clr`+`load`+`start` → `clr` wins: IDLE with `count`=000. Assert `reset_n`=0 mid-RUN → all outputs 0 immediately.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the three-digit BCD counter.
// Includes the load-value digit check used by the controller.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [11:0] BCD_MAX   = 12'h999;
  localparam logic [3:0]  DIGIT_MAX = 4'd9;

  function automatic logic bcd_valid3(input logic [11:0] v);
    bcd_valid3 = (v[3:0] <= DIGIT_MAX) && (v[7:4] <= DIGIT_MAX) && (v[11:8] <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_count_ctrl_inc3.sv
// Purely combinational three-digit BCD incrementer built from
// chained single-digit bcd_incrementer cells.
module bcd_incrementer (
  input  logic [3:0] digit_in,
  input  logic       inc,
  output logic [3:0] digit_out,
  output logic       carry
);
  import bcd_pkg::*;

  always_comb begin
    digit_out = digit_in;
    carry     = 1'b0;
    if (inc) begin
      if (digit_in >= DIGIT_MAX) begin
        digit_out = 4'd0;
        carry     = 1'b1;
      end else begin
        digit_out = digit_in + 4'd1;
      end
    end
  end
endmodule

module bcd_count_inc3 (
  input  logic [11:0] count_in,
  input  logic        en,
  output logic [11:0] count_out,
  output logic        carry_out
);
  logic [3:0] carry_chain;

  assign carry_chain[0] = en;
  assign carry_out      = carry_chain[3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_digit
      bcd_incrementer u_digit (
        .digit_in  (count_in[4*gi +: 4]),
        .inc       (carry_chain[gi]),
        .digit_out (count_out[4*gi +: 4]),
        .carry     (carry_chain[gi+1])
      );
    end
  endgenerate
endmodule

// File: rtl/bcd_count_ctrl.sv
// Sequencing controller for the three-digit BCD counter: command decode,
// tick prescaler, terminal-count handling and registered status flags.
module bcd_count_ctrl
  import bcd_pkg::*;
#(
  parameter int DIV         = 1,
  parameter bit STOP_AT_MAX = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        clr,
  input  logic        load,
  input  logic [11:0] load_val,
  input  logic        tick,
  output logic [11:0] count,
  output logic        running,
  output logic        done,
  output logic        wrap,
  output logic        ovf,
  output logic        load_err
);

  localparam int              PRE_W    = (DIV <= 1) ? 1 : $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  state_e           state_q, state_d;
  logic [11:0]      count_q, count_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             ovf_q, ovf_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic             running_q, running_d;
  logic             done_q, done_d;

  logic             tick_run;
  logic             tick_hit;
  logic [11:0]      inc_val;
  logic             inc_carry;

  // A tick only reaches the prescaler when no higher-priority command is present.
  assign tick_run = tick && !clr && !load && !stop && !start && (state_q == ST_RUN);
  assign tick_hit = tick_run && (pre_q == PRE_LAST);

  bcd_count_inc3 u_inc3 (
    .count_in  (count_q),
    .en        (tick_hit),
    .count_out (inc_val),
    .carry_out (inc_carry)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pre_d      = pre_q;
    ovf_d      = ovf_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;

    if (clr) begin
      count_d = '0;
      pre_d   = '0;
      ovf_d   = 1'b0;
      state_d = ST_IDLE;
    end else if (load) begin
      if (bcd_valid3(load_val)) begin
        count_d = load_val;
        pre_d   = '0;
        if (state_q == ST_DONE) state_d = ST_IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (stop) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else if (start) begin
      if (state_q == ST_IDLE || state_q == ST_PAUSE) state_d = ST_RUN;
    end else if (tick_run) begin
      if (tick_hit) begin
        pre_d = '0;
        // Carry-out means the count was 999; terminal mode holds instead of wrapping.
        if (STOP_AT_MAX && inc_carry) begin
          state_d = ST_DONE;
        end else begin
          count_d = inc_val;
          if (inc_carry) begin
            wrap_d = 1'b1;
            ovf_d  = 1'b1;
          end
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      pre_q      <= '0;
      ovf_q      <= 1'b0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pre_q      <= pre_d;
      ovf_q      <= ovf_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
      running_q  <= running_d;
      done_q     <= done_d;
    end
  end

  assign count    = count_q;
  assign running  = running_q;
  assign done     = done_q;
  assign wrap     = wrap_q;
  assign ovf      = ovf_q;
  assign load_err = load_err_q;

endmodule
